// File: rtl/energy_accumulator_pkg.sv
// energy_pkg: shared types and width helpers for the spin-frame energy accumulator.
//   state_t          : frame FSM states (IDLE, ACCUM, DONE)
//   dot_width()      : width of one signed column dot product from the dot-product tree
//   energy_width()   : exact-fit width of the accumulated quadratic form
//   beat_sum_width() : width of one beat's spin-weighted lane sum; carries one spare
//                      bit so negating the most-negative dot product cannot overflow
package energy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int dot_width(input int j_element_width, input int vector_size);
        return (j_element_width + 1) + $clog2(vector_size);
    endfunction

    function automatic int energy_width(input int dot_w, input int vector_size);
        return dot_w + $clog2(vector_size);
    endfunction

    function automatic int beat_sum_width(input int dot_w, input int lanes);
        return dot_w + $clog2(lanes) + 1;
    endfunction

endpackage

// File: rtl/energy_accumulator_spin_weighted_sum.sv
// spin_weighted_sum: combinational sign-select plus pairwise adder tree.
//   sigma_slice : spins for the LANES columns of the current beat (1 -> +dot, 0 -> -dot)
//   dot_in      : LANES signed dot products, lane l in dot_in[l]
//   sum_b       : signed sum of the spin-weighted lanes
module spin_weighted_sum
    import energy_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int DOT_WIDTH = 8,
    parameter int SUM_W     = beat_sum_width(DOT_WIDTH, LANES)
) (
    input  logic [LANES-1:0]                sigma_slice,
    input  logic [LANES-1:0][DOT_WIDTH-1:0] dot_in,
    output logic signed [SUM_W-1:0]         sum_b
);

    logic signed [SUM_W-1:0] term [LANES];
    logic signed [SUM_W-1:0] tree [LANES];

    // Widen before negating so -(-2^(DOT_WIDTH-1)) is representable.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : gen_term
            logic signed [DOT_WIDTH-1:0] lane_dot;
            logic signed [SUM_W-1:0]     lane_ext;
            assign lane_dot  = dot_in[gi];
            assign lane_ext  = SUM_W'(lane_dot);
            assign term[gi]  = sigma_slice[gi] ? lane_ext : -lane_ext;
        end
    endgenerate

    // In-place pairwise reduction: each pass halves the live span, giving
    // a balanced tree of depth log2(LANES).
    always_comb begin
        tree = term;
        for (int span = LANES / 2; span >= 1; span = span / 2) begin
            for (int i = 0; i < span; i++) begin
                tree[i] = tree[2*i] + tree[2*i+1];
            end
        end
        sum_b = tree[0];
    end

endmodule

// File: rtl/energy_accumulator.sv
// energy_accumulator: accumulates spin-weighted column dot products into
// sigma^T J sigma for one spin frame and hands the result downstream.
//   clk, rst        : clock, asynchronous active-high reset
//   sigma           : spin vector, captured on an accepted frame_start
//   frame_start     : single-cycle pulse starting (or restarting) a frame
//   dot_in          : LANES signed dot products; lane l is column batch*LANES+l
//   dot_valid       : per-lane valid; a beat is all lanes valid
//   energy_out      : frame result, held while energy_valid waits for energy_ready
//   energy_valid    : result available
//   energy_ready    : downstream accepts the result
//   busy            : frame accumulation in progress
//   drop_err        : sticky, a beat arrived outside accumulation
//   lane_err        : sticky, dot_valid was a partial lane set
module energy_accumulator
    import energy_pkg::*;
#(
    parameter int VECTOR_SIZE     = 256,
    parameter int LANES           = 4,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int DOT_WIDTH       = dot_width(J_ELEMENT_WIDTH, VECTOR_SIZE),
    parameter int ENERGY_WIDTH    = energy_width(DOT_WIDTH, VECTOR_SIZE)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [VECTOR_SIZE-1:0]          sigma,
    input  logic                            frame_start,
    input  logic [LANES-1:0][DOT_WIDTH-1:0] dot_in,
    input  logic [LANES-1:0]                dot_valid,
    output logic signed [ENERGY_WIDTH-1:0]  energy_out,
    output logic                            energy_valid,
    input  logic                            energy_ready,
    output logic                            busy,
    output logic                            drop_err,
    output logic                            lane_err
);

    localparam int NUM_BATCHES = VECTOR_SIZE / LANES;
    localparam int BATCH_W     = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
    localparam int SUM_W       = beat_sum_width(DOT_WIDTH, LANES);

    state_t                         state_q, state_d;
    logic [BATCH_W-1:0]             batch_q, batch_d;
    logic signed [ENERGY_WIDTH-1:0] acc_q, acc_d;
    logic signed [ENERGY_WIDTH-1:0] energy_q, energy_d;
    logic [VECTOR_SIZE-1:0]         sigma_q, sigma_d;
    logic                           valid_q, valid_d;
    logic                           drop_q, drop_d;
    logic                           lane_q, lane_d;

    logic                           beat;
    logic                           lane_partial;
    logic                           last_batch;
    logic [LANES-1:0]               sigma_slice;
    logic signed [SUM_W-1:0]        sum_b;
    logic signed [ENERGY_WIDTH-1:0] acc_sum;

    assign beat         = &dot_valid;
    assign lane_partial = (|dot_valid) && !beat;
    assign last_batch   = (batch_q == BATCH_W'(NUM_BATCHES - 1));
    assign sigma_slice  = sigma_q[int'(batch_q) * LANES +: LANES];
    // The energy range is exact-fit, so resizing the beat sum loses nothing
    // for any in-range frame.
    assign acc_sum      = acc_q + ENERGY_WIDTH'(sum_b);

    spin_weighted_sum #(
        .LANES     (LANES),
        .DOT_WIDTH (DOT_WIDTH),
        .SUM_W     (SUM_W)
    ) u_sum (
        .sigma_slice (sigma_slice),
        .dot_in      (dot_in),
        .sum_b       (sum_b)
    );

    always_comb begin
        state_d  = state_q;
        batch_d  = batch_q;
        acc_d    = acc_q;
        energy_d = energy_q;
        sigma_d  = sigma_q;
        valid_d  = valid_q;
        drop_d   = drop_q | (beat && (state_q != ACCUM));
        lane_d   = lane_q | lane_partial;

        case (state_q)
            ACCUM: begin
                // A restart takes priority and discards a same-cycle beat.
                if (!frame_start && beat) begin
                    acc_d   = acc_sum;
                    batch_d = batch_q + BATCH_W'(1);
                    if (last_batch) begin
                        energy_d = acc_sum;
                        valid_d  = 1'b1;
                        batch_d  = '0;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (energy_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // frame_start is accepted in IDLE and ACCUM, and in DONE only when the
        // pending result is handed off the same cycle.
        if (frame_start && ((state_q != DONE) || energy_ready)) begin
            sigma_d = sigma;
            acc_d   = '0;
            batch_d = '0;
            drop_d  = 1'b0;
            lane_d  = 1'b0;
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            batch_q  <= '0;
            acc_q    <= '0;
            energy_q <= '0;
            sigma_q  <= '0;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
            lane_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            batch_q  <= batch_d;
            acc_q    <= acc_d;
            energy_q <= energy_d;
            sigma_q  <= sigma_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
            lane_q   <= lane_d;
        end
    end

    assign energy_out   = energy_q;
    assign energy_valid = valid_q;
    assign busy         = (state_q == ACCUM);
    assign drop_err     = drop_q;
    assign lane_err     = lane_q;

endmodule
